// File: rtl/tcm_pkg.sv
// Shared types and helpers for the dual-port tightly-coupled memory.
package tcm_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_CLEAR,
    S_READY
  } tcm_state_e;

  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_word,
                                                   input logic [MAX_DW-1:0] new_word,
                                                   input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tcm_port_resp.sv
// Per-port address decode, error check and registered one-cycle response.
module tcm_port_resp
  import tcm_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 4096,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_word,
  output logic [IDX_W-1:0]  idx,
  output logic              bad,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int BW = be_width(DATA_W);
  localparam int OB = off_bits(DATA_W);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BW);

  logic [ADDR_W-1:0] off;

  // Below-base addresses wrap to huge offsets and so fail the range test.
  assign off = addr - BASE_ADDR;
  assign idx = IDX_W'(off >> OB);
  assign bad = ((off & ADDR_W'(BW - 1)) != '0) || ({1'b0, off} >= SPAN);

  // Response registers: data only for good reads, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      rvalid <= 1'b1;
      err    <= bad;
      rdata  <= (bad || we) ? '0 : rd_word;
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end
  end

endmodule

// File: rtl/tcm_dual.sv
// Dual-port TCM: read-only fetch port A, byte-strobed read/write port B,
// with an optional post-reset clear sequence that holds off all grants.
module tcm_dual
  import tcm_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 4096,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_req_i,
  input  logic [ADDR_W-1:0]           a_addr_i,
  output logic                        a_gnt_o,
  output logic                        a_rvalid_o,
  output logic [DATA_W-1:0]           a_rdata_o,
  output logic                        a_err_o,
  input  logic                        b_req_i,
  input  logic                        b_we_i,
  input  logic [be_width(DATA_W)-1:0] b_be_i,
  input  logic [ADDR_W-1:0]           b_addr_i,
  input  logic [DATA_W-1:0]           b_wdata_i,
  output logic                        b_gnt_o,
  output logic                        b_rvalid_o,
  output logic [DATA_W-1:0]           b_rdata_o,
  output logic                        b_err_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  tcm_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic clr_we;

  logic gnt, a_acc, b_acc, b_wr, collide;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic a_bad, b_bad;
  logic [DATA_W-1:0] a_old, b_old, a_word, b_merged;

  // Grants are masked by rst so nothing is accepted on the reset edge.
  assign gnt     = (state_q == S_READY) && !rst;
  assign a_gnt_o = gnt;
  assign b_gnt_o = gnt;
  assign busy_o  = (state_q == S_CLEAR) && !rst;

  assign a_acc = a_req_i && gnt;
  assign b_acc = b_req_i && gnt;
  assign b_wr  = b_acc && b_we_i && !b_bad;

  assign a_old    = mem[a_idx];
  assign b_old    = mem[b_idx];
  assign b_merged = DATA_W'(byte_merge(MAX_DW'(b_old), MAX_DW'(b_wdata_i), MAX_BE'(b_be_i)));

  // Same-word write on B forwards its strobed bytes to the A read (write-first).
  assign collide = b_wr && (a_idx == b_idx);
  assign a_word  = collide
                 ? DATA_W'(byte_merge(MAX_DW'(a_old), MAX_DW'(b_wdata_i), MAX_BE'(b_be_i)))
                 : a_old;

  tcm_port_resp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_resp_a (
    .clk(clk), .rst(rst), .accept(a_acc), .we(1'b0), .addr(a_addr_i), .rd_word(a_word),
    .idx(a_idx), .bad(a_bad), .rvalid(a_rvalid_o), .rdata(a_rdata_o), .err(a_err_o)
  );

  tcm_port_resp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_resp_b (
    .clk(clk), .rst(rst), .accept(b_acc), .we(b_we_i), .addr(b_addr_i), .rd_word(b_old),
    .idx(b_idx), .bad(b_bad), .rvalid(b_rvalid_o), .rdata(b_rdata_o), .err(b_err_o)
  );

  // Clear-sequencer next state: walk cnt over every word, then open for business.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_RESET: begin
        cnt_d   = '0;
        state_d = CLEAR_ON_RESET ? S_CLEAR : S_READY;
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      S_READY: ;
      default: state_d = S_RESET;
    endcase
  end

  // State and clear counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write port: clear sequence or strobed port B write; never reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)    mem[cnt_q] <= '0;
      else if (b_wr) mem[b_idx] <= b_merged;
    end
  end

endmodule

// File: tb/tb_tcm_dual.sv
// Scoreboard bench for tcm_dual: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever a port responds.
module tb_tcm_dual;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h100;

  logic        clk, rst;
  logic        a_req_i, a_gnt_o, a_rvalid_o, a_err_o;
  logic [31:0] a_addr_i, a_rdata_o;
  logic        b_req_i, b_we_i, b_gnt_o, b_rvalid_o, b_err_o, busy_o;
  logic [3:0]  b_be_i;
  logic [31:0] b_addr_i, b_wdata_i, b_rdata_o;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];
  resp_t ea, eb;
  int n_pass  = 0;
  int n_total = 0;

  tcm_dual #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: rvalid must match whether a response is owed; data/err checked or held at 0.
  always @(negedge clk) begin
    checkOutput("a_rvalid", 32'(a_rvalid_o), 32'(qa.size() > 0));
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      if (a_rvalid_o) begin
        checkOutput("a_rdata", a_rdata_o, ea.data);
        checkOutput("a_err", 32'(a_err_o), 32'(ea.err));
      end
    end else if (!a_rvalid_o) begin
      checkOutput("a_idle_rdata_err", {a_rdata_o[31:1], a_rdata_o[0] | a_err_o}, 32'h0);
    end
    checkOutput("b_rvalid", 32'(b_rvalid_o), 32'(qb.size() > 0));
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      if (b_rvalid_o) begin
        checkOutput("b_rdata", b_rdata_o, eb.data);
        checkOutput("b_err", 32'(b_err_o), 32'(eb.err));
      end
    end else if (!b_rvalid_o) begin
      checkOutput("b_idle_rdata_err", {b_rdata_o[31:1], b_rdata_o[0] | b_err_o}, 32'h0);
    end
  end

  // One request cycle on either or both ports, queuing the hand-computed responses.
  task automatic applyStimulus(input logic ar, input logic [31:0] aa,
                               input logic br, input logic bw, input logic [3:0] bbe,
                               input logic [31:0] ba, input logic [31:0] bd,
                               input logic [31:0] ead, input logic eae,
                               input logic [31:0] ebd, input logic ebe);
    @(negedge clk);
    a_req_i = ar; a_addr_i = aa;
    b_req_i = br; b_we_i = bw; b_be_i = bbe; b_addr_i = ba; b_wdata_i = bd;
    if (ar) checkOutput("a_gnt", 32'(a_gnt_o), 32'd1);
    if (br) checkOutput("b_gnt", 32'(b_gnt_o), 32'd1);
    @(posedge clk);
    #1;
    if (ar) qa.push_back('{data: ead, err: eae});
    if (br) qb.push_back('{data: ebd, err: ebe});
    a_req_i = 1'b0; b_req_i = 1'b0; b_we_i = 1'b0;
  endtask

  // Hold reset, release it and time the clear sequence and first grant.
  task automatic resetAndCheck(input int hold);
    int busy_cnt, first_gnt;
    @(negedge clk);
    rst = 1'b1;
    repeat (hold) @(negedge clk);
    checkOutput("rst_gnt", 32'(a_gnt_o | b_gnt_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_gnt", 32'(a_gnt_o | b_gnt_o), 32'd0);
    checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
    busy_cnt  = 0;
    first_gnt = -1;
    for (int n = 1; n <= 60 && first_gnt < 0; n++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (a_gnt_o && b_gnt_o) first_gnt = n;
    end
    checkOutput("clear_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    checkOutput("first_gnt_cycle", 32'(first_gnt), 32'(DEPTH + 1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_req_i = 1'b0; a_addr_i = '0;
    b_req_i = 1'b0; b_we_i = 1'b0; b_be_i = '0; b_addr_i = '0; b_wdata_i = '0;

    resetAndCheck(3);

    // Streaming reads over the cleared array, both ports every cycle
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0, 4'h0, BASE + 32'(4 * (DEPTH - 1 - i)),
                    32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Strobed write then read-back on both ports
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h108, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 4'h0, 32'h108, 32'h0, 32'h00AD00EF, 1'b0, 32'h00AD00EF, 1'b0);

    // Collisions: A read same word as B write sees the written bytes
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h104, 32'hAAAAAAAA, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 4'hF, 32'h104, 32'h11223344, 32'h11223344, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 4'h8, 32'h104, 32'h55667788, 32'h55223344, 1'b0, 32'h0, 1'b0);

    // Re-read plus a zero-strobe write that must leave the word alone
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 4'h0, 32'h108, 32'hFFFFFFFF, 32'h55223344, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00AD00EF, 1'b0, 32'h0, 1'b0);

    // Error accesses: past the end, below base, misaligned write and read
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b1, 4'hF, 32'h102, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0FC, 1'b1, 1'b0, 4'h0, 32'h105, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 4'h0, 32'h13C, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Last word write, then read on both ports next cycle
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h13C, 32'h12345678, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h13C, 1'b1, 1'b0, 4'h0, 32'h13C, 32'h0, 32'h12345678, 1'b0, 32'h12345678, 1'b0);

    // A request coinciding with reset must never produce a response
    @(negedge clk);
    rst = 1'b1; a_req_i = 1'b1; a_addr_i = 32'h108;
    @(negedge clk);
    a_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the clear sequence (cnt = 5), then a full restart
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy_mid_clear", 32'(busy_o), 32'd1);
    rst = 1'b1;
    resetAndCheck(2);

    // Array was zeroed again by the completed clear
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 4'h0, 32'h13C, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("a_queue_drained", 32'(qa.size()), 32'd0);
    checkOutput("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
